// File: rtl/mac_t_gmii_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_mon_pkg
//  Description : Shared types and constants for the transmit-side GMII
//                frame monitor: FSM state encoding, preamble/SFD bytes,
//                CRC32 constants, PTP ethertype and status-word bit map.
//                The optional PTP detection in the monitor top is enabled
//                with the macro MAC_MON_PTP_DETECT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_mon_pkg;

    // Monitor FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_BODY = 2'd2
    } mon_state_e;

    // Same encoding as plain constants for legacy code that keeps the
    // state in a bare logic vector
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;

    // Frame framing bytes
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [3:0]  PREAMBLE_CNT  = 4'd7;

    // CRC32 (IEEE 802.3). The register is kept in shift-left form with
    // data bits entering LSB first, so a frame with a correct FCS leaves
    // the register at CRC_RESIDUE.
    localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;

    // IEEE 1588 over Ethernet
    localparam logic [15:0] PTP_ETYPE     = 16'h88F7;

    // Status word layout
    localparam int          STATUS_W      = 16;
    localparam int          LEN_W         = 11;
    localparam logic [LEN_W-1:0] LEN_SAT  = '1;
    localparam int          STAT_CRC_BIT  = 15;
    localparam int          STAT_PRE_BIT  = 14;
    localparam int          STAT_LEN_BIT  = 13;
    localparam int          STAT_IFG_BIT  = 12;
    localparam int          STAT_PTP_BIT  = 11;

endpackage : mac_mon_pkg
`default_nettype wire

// File: rtl/mac_t_gmii_mon_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_t_gmii_mon_if
//  Description : Bundle between the MAC transmit GMII output, the frame
//                monitor and the status FIFO.
//                  gtx_dv / gtx_d      GMII transmit data from the MAC
//                  status_fifo_full    status FIFO back-pressure
//                  status_fifo_wr/din  one status word per frame
//                slave  : monitor view
//                master : environment view (MAC + status FIFO)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mac_t_gmii_mon_if;
    import mac_mon_pkg::*;

    logic                gtx_dv;
    logic [7:0]          gtx_d;
    logic                status_fifo_full;
    logic                status_fifo_wr;
    logic [STATUS_W-1:0] status_fifo_din;

    modport slave (
        input  gtx_dv,
        input  gtx_d,
        input  status_fifo_full,
        output status_fifo_wr,
        output status_fifo_din
    );

    modport master (
        output gtx_dv,
        output gtx_d,
        output status_fifo_full,
        input  status_fifo_wr,
        input  status_fifo_din
    );

endinterface : mac_t_gmii_mon_if
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_d8
//  Description : Combinational IEEE 802.3 CRC32 update for one byte.
//                Bits of d are consumed LSB first (GMII bit order).
//                Ports:
//                  crc_in  [31:0]  current CRC register
//                  d       [7:0]   data byte
//                  crc_out [31:0]  register after the byte
//  Revision    : 1.0 - initial release
// ============================================================================
module crc32_d8
    import mac_mon_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    logic [31:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        crc_out = c;
    end

endmodule : crc32_d8
`default_nettype wire

// File: rtl/mac_t_gmii_mon.sv
`default_nettype none
// ============================================================================
//  Module      : mac_t_gmii_mon
//  Description : Passive transmit-side GMII frame monitor. Checks
//                preamble/SFD, CRC32, length and inter-frame gap of each
//                frame and writes one status word per frame to a status
//                FIFO, plus saturating frame/error/drop counters.
//                Optional: MAC_MON_PTP_DETECT_EN adds PTP (0x88F7) frame
//                detection, status bit [11] and the ptp_cnt port.
//  Ports       : interface_clk  monitor clock
//                rstn           synchronous active-low reset
//                bus            GMII in + status FIFO out (slave modport)
//                frame_cnt      frames ended
//                err_cnt        frames with any error flag
//                drop_cnt       status words lost to a full FIFO
//                ptp_cnt        PTP frames (only with the macro)
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_t_gmii_mon
    import mac_mon_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int MIN_IFG = 12,
    parameter int CNT_W   = 16
) (
    input  logic             interface_clk,
    input  logic             rstn,
    mac_t_gmii_mon_if.slave  bus,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] drop_cnt
`ifdef MAC_MON_PTP_DETECT_EN
    ,
    output logic [CNT_W-1:0] ptp_cnt
`endif
);

    localparam int               IFG_W     = $clog2(MIN_IFG + 1);
    localparam logic [IFG_W-1:0] IFG_MIN_L = IFG_W'(MIN_IFG);
    localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [1:0]          state;
    logic                dv_q;
    logic [3:0]          pre_cnt;
    logic                pre_err;
    logic                ifg_err;
    logic [LEN_W-1:0]    len;
    logic [31:0]         crc;
    logic [31:0]         crc_next;
    logic [IFG_W-1:0]    ifg_cnt;
    logic                pend;
    logic [STATUS_W-1:0] status_q;

    logic                frame_start;
    logic                frame_end;
    logic                in_pre;
    logic [3:0]          pre_cnt_cur;
    logic                pre_is_55;
    logic                pre_is_sfd;
    logic [3:0]          pre_cnt_inc;
    logic [LEN_W-1:0]    end_len;
    logic                end_crc_err;
    logic                end_pre_err;
    logic                end_len_err;
    logic                end_ptp;
    logic [STATUS_W-1:0] end_status;
    logic                status_any_err;

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc),
        .d       (bus.gtx_d),
        .crc_out (crc_next)
    );

    // A frame only starts on a dv rising edge. dv_q resets high so that a
    // frame still in flight when reset is released is ignored to its end.
    assign frame_start = (state == S_IDLE) && bus.gtx_dv && !dv_q;
    assign frame_end   = (state != S_IDLE) && !bus.gtx_dv;
    assign in_pre      = (state == S_PRE);

    // The start byte is preamble byte 1, so it is evaluated with a count of 0
    assign pre_cnt_cur = (state == S_IDLE) ? 4'd0 : pre_cnt;
    assign pre_is_55   = (bus.gtx_d == PREAMBLE_BYTE);
    assign pre_is_sfd  = (bus.gtx_d == SFD_BYTE);
    assign pre_cnt_inc = (pre_cnt_cur == 4'hF) ? pre_cnt_cur : pre_cnt_cur + 4'd1;

    // Frame-end evaluation; dv dropping inside the preamble reports an
    // empty frame with preamble and CRC errors
    assign end_len     = in_pre ? '0 : len;
    assign end_crc_err = in_pre || (crc != CRC_RESIDUE);
    assign end_pre_err = in_pre || pre_err;
    assign end_len_err = (end_len < MIN_LEN_L) || (end_len > MAX_LEN_L);

`ifdef MAC_MON_PTP_DETECT_EN
    logic [15:0] etype;
    assign end_ptp = !in_pre && (etype == PTP_ETYPE);

    always_ff @(posedge interface_clk) begin
        if (!rstn) begin
            etype <= '0;
        end else if (frame_start) begin
            etype <= '0;
        end else if (state == S_BODY && bus.gtx_dv) begin
            if (len == LEN_W'(12)) etype[15:8] <= bus.gtx_d;
            if (len == LEN_W'(13)) etype[7:0]  <= bus.gtx_d;
        end
    end
`else
    assign end_ptp = 1'b0;
`endif

    always_comb begin
        end_status               = '0;
        end_status[STAT_CRC_BIT] = end_crc_err;
        end_status[STAT_PRE_BIT] = end_pre_err;
        end_status[STAT_LEN_BIT] = end_len_err;
        end_status[STAT_IFG_BIT] = ifg_err;
        end_status[STAT_PTP_BIT] = end_ptp;
        end_status[LEN_W-1:0]    = end_len;
    end

    assign status_any_err = |status_q[STAT_CRC_BIT:STAT_IFG_BIT];

    // Frame FSM, length and CRC
    always_ff @(posedge interface_clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            dv_q    <= 1'b1;
            pre_cnt <= '0;
            pre_err <= 1'b0;
            ifg_err <= 1'b0;
            len     <= '0;
            crc     <= CRC_INIT;
        end else begin
            dv_q <= bus.gtx_dv;
            if (frame_end) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (frame_start) begin
                            ifg_err <= (ifg_cnt < IFG_MIN_L);
                            pre_err <= 1'b0;
                            len     <= '0;
                            crc     <= CRC_INIT;
                            if (pre_is_55) begin
                                state   <= S_PRE;
                                pre_cnt <= pre_cnt_inc;
                            end else begin
                                // Bad first byte or SFD with no preamble
                                state   <= S_BODY;
                                pre_err <= 1'b1;
                                pre_cnt <= '0;
                            end
                        end
                    end
                    S_PRE: begin
                        if (pre_is_55) begin
                            pre_cnt <= pre_cnt_inc;
                        end else begin
                            state <= S_BODY;
                            if (!pre_is_sfd || (pre_cnt_cur != PREAMBLE_CNT)) begin
                                pre_err <= 1'b1;
                            end
                        end
                    end
                    S_BODY: begin
                        if (len != LEN_SAT) len <= len + LEN_W'(1);
                        crc <= crc_next;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Idle-gap counter; the falling-edge cycle is the first idle cycle
    always_ff @(posedge interface_clk) begin
        if (!rstn) begin
            ifg_cnt <= IFG_MIN_L;
        end else if (frame_end) begin
            ifg_cnt <= IFG_W'(1);
        end else if (!bus.gtx_dv && (ifg_cnt < IFG_MIN_L)) begin
            ifg_cnt <= ifg_cnt + IFG_W'(1);
        end
    end

    // Status word is registered on the frame end and offered one cycle later
    always_ff @(posedge interface_clk) begin
        if (!rstn) begin
            pend     <= 1'b0;
            status_q <= '0;
        end else begin
            pend <= frame_end;
            if (frame_end) status_q <= end_status;
        end
    end

    assign bus.status_fifo_wr  = pend && !bus.status_fifo_full;
    assign bus.status_fifo_din = status_q;

    // Saturating statistics, updated in the status cycle
    always_ff @(posedge interface_clk) begin
        if (!rstn) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
            drop_cnt  <= '0;
        end else if (pend) begin
            if (frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
            if (status_any_err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
            if (bus.status_fifo_full && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

`ifdef MAC_MON_PTP_DETECT_EN
    always_ff @(posedge interface_clk) begin
        if (!rstn) begin
            ptp_cnt <= '0;
        end else if (pend && status_q[STAT_PTP_BIT] && (ptp_cnt != '1)) begin
            ptp_cnt <= ptp_cnt + CNT_W'(1);
        end
    end
`endif

endmodule : mac_t_gmii_mon
`default_nettype wire

// File: tb/tb_mac_t_gmii_mon.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_t_gmii_mon
//  Description : Scoreboard bench for mac_t_gmii_mon. Directed frames push
//                their hand-computed status word into a queue; a monitor
//                compares every status FIFO write against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_t_gmii_mon;

    logic        clk;
    logic        rstn;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
    logic [15:0] drop_cnt;
`ifdef MAC_MON_PTP_DETECT_EN
    logic [15:0] ptp_cnt;
`endif

    int          checks;
    int          errors;
    logic [15:0] exp_q[$];
    logic [7:0]  fb[2048];
    int          exp_frames;
    int          exp_errs;

    mac_t_gmii_mon_if bus ();

    mac_t_gmii_mon #(
        .MIN_LEN (64),
        .MAX_LEN (1518),
        .MIN_IFG (12),
        .CNT_W   (16)
    ) dut (
        .interface_clk (clk),
        .rstn          (rstn),
        .bus           (bus),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt),
        .drop_cnt      (drop_cnt)
`ifdef MAC_MON_PTP_DETECT_EN
        ,
        .ptp_cnt       (ptp_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest expected status
    always @(negedge clk) begin
        if (bus.status_fifo_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got din %h, expected no write", bus.status_fifo_din);
            end else begin
                chk("status_word", {16'h0, bus.status_fifo_din}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic put(input logic dv, input logic [7:0] d);
        bus.gtx_dv = dv;
        bus.gtx_d  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 8'h00);
    endtask

    // Builds nbytes of frame (FCS included) with an independent reflected
    // CRC32 model, then drives preamble, SFD, body and the idle gap.
    task automatic send_frame(input int pre_n, input int nbytes, input bit bad_fcs,
                              input bit ptp, input int ifg, input bit expect_wr,
                              input logic [15:0] exp_status);
        logic [31:0] c;
        for (int i = 0; i < nbytes - 4; i++) fb[i] = 8'($urandom_range(0, 255));
        fb[12] = ptp ? 8'h88 : 8'h08;
        fb[13] = ptp ? 8'hF7 : 8'h00;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < nbytes - 4; i++) begin
            c = c ^ {24'h0, fb[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        fb[nbytes-4] = c[7:0];
        fb[nbytes-3] = c[15:8];
        fb[nbytes-2] = c[23:16];
        fb[nbytes-1] = c[31:24];
        if (bad_fcs) fb[nbytes-1] = fb[nbytes-1] ^ 8'h01;
        if (expect_wr) exp_q.push_back(exp_status);
        for (int i = 0; i < pre_n; i++) put(1'b1, 8'h55);
        put(1'b1, 8'hD5);
        for (int i = 0; i < nbytes; i++) put(1'b1, fb[i]);
        idle(ifg);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_frame_cnt"}, {16'h0, frame_cnt}, exp_frames);
        chk({tag, "_err_cnt"},   {16'h0, err_cnt},   exp_errs);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        exp_frames  = 0;
        exp_errs    = 0;
        rstn        = 1'b0;
        bus.gtx_dv  = 1'b0;
        bus.gtx_d   = 8'h00;
        bus.status_fifo_full = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_wr",    {31'h0, bus.status_fifo_wr}, 32'h0);
        chk("reset_din",   {16'h0, bus.status_fifo_din}, 32'h0);
        chk("reset_frame", {16'h0, frame_cnt}, 32'h0);
        chk("reset_err",   {16'h0, err_cnt},   32'h0);
        chk("reset_drop",  {16'h0, drop_cnt},  32'h0);
        rstn = 1'b1;
        idle(2);

        // Good 64-byte frame: first frame after reset, no IFG flag
        send_frame(7, 64, 1'b0, 1'b0, 12, 1'b1, 16'h0040);
        exp_frames = 1; chk_counters("good64");

        // Corrupted FCS
        send_frame(7, 64, 1'b1, 1'b0, 12, 1'b1, 16'h8040);
        exp_frames = 2; exp_errs = 1; chk_counters("badfcs");

        // Short preamble
        send_frame(6, 64, 1'b0, 1'b0, 12, 1'b1, 16'h4040);
        exp_frames = 3; exp_errs = 2; chk_counters("pre6");

        // Back-to-back: 8 idle cycles before the second frame
        send_frame(7, 64, 1'b0, 1'b0, 8,  1'b1, 16'h0040);
        send_frame(7, 64, 1'b0, 1'b0, 12, 1'b1, 16'h1040);
        exp_frames = 5; exp_errs = 3; chk_counters("ifg8");

        // Length boundaries
        send_frame(7, 1518, 1'b0, 1'b0, 12, 1'b1, 16'h05EE);
        send_frame(7, 1519, 1'b0, 1'b0, 12, 1'b1, 16'h25EF);
        send_frame(7, 40,   1'b0, 1'b0, 12, 1'b1, 16'h2028);
        exp_frames = 8; exp_errs = 5; chk_counters("len");

        // Status FIFO full: word dropped
        bus.status_fifo_full = 1'b1;
        send_frame(7, 64, 1'b0, 1'b0, 12, 1'b0, 16'h0000);
        bus.status_fifo_full = 1'b0;
        exp_frames = 9; chk_counters("full");
        chk("full_drop_cnt", {16'h0, drop_cnt}, 32'd1);

        // dv drops inside the preamble
        exp_q.push_back(16'hE000);
        for (int i = 0; i < 3; i++) put(1'b1, 8'h55);
        idle(12);
        exp_frames = 10; exp_errs = 6; chk_counters("preabort");

`ifdef MAC_MON_PTP_DETECT_EN
        send_frame(7, 64, 1'b0, 1'b1, 12, 1'b1, 16'h0840);
        exp_frames = 11; chk_counters("ptp");
        chk("ptp_cnt", {16'h0, ptp_cnt}, 32'd1);
`endif

        // Reset in the middle of a frame body; dv still high at release
        for (int i = 0; i < 7; i++) put(1'b1, 8'h55);
        put(1'b1, 8'hD5);
        for (int i = 0; i < 30; i++) put(1'b1, 8'($urandom_range(0, 255)));
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) put(1'b1, 8'hA5);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) put(1'b1, 8'hA5);
        idle(12);
        exp_frames = 0; exp_errs = 0; chk_counters("midreset");
        chk("midreset_drop", {16'h0, drop_cnt}, 32'd0);
        send_frame(7, 64, 1'b0, 1'b0, 12, 1'b1, 16'h0040);
        exp_frames = 1; chk_counters("after_reset");

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mac_t_gmii_mon
`default_nettype wire
